tick_timer_sched: RTL and testbench
===================================

TICK_TIMER_SCHED -- requirements
Module: tick_timer_sched

Interface
REQ-001 Parameter DIV, default 5000000, number of clk cycles per timebase tick (0.1 s at 50 MHz); legal range >= 1.
REQ-002 Parameter CNT_W, default 16, width of each channel countdown value in ticks.
REQ-003 Port clk, input, 1, single system clock; all state updates on the posedge.
REQ-004 Port rst, input, 1, asynchronous, active-low reset: clears all state immediately while low.
REQ-005 Port req, input, 4, per-channel start request; held high until the matching gnt bit is seen.
REQ-006 Port load_val, input, 4*CNT_W, per-channel start value; channel i uses bits [i*CNT_W +: CNT_W].
REQ-007 Port cancel, input, 4, per-channel abort of a running countdown.
REQ-008 Port gnt, output, 4, combinational one-hot grant; the load occurs at the clock edge ending the grant cycle.
REQ-009 Port busy, output, 4, registered flag; high while the channel is counting.
REQ-010 Port done, output, 4, registered one-cycle expiry pulse per channel.
REQ-011 Port tick, output, 1, registered one-cycle timebase pulse.

Function
REQ-012 The prescaler shall count 0..DIV-1 and wrap to 0; tick shall be high for the single cycle after the edge at which the count wraps; with DIV=1, tick shall be high every cycle after reset.
REQ-013 Arbitration: at most one gnt bit per cycle; eligible channels have req=1 and busy=0; a req from a busy channel is ignored until the channel goes idle.
REQ-014 Round-robin: search starts at pointer ptr (reset 0); after a grant to channel i, ptr becomes (i+1) mod 4; ptr is unchanged if no grant.
REQ-015 Grant edge: channel count <= load_val slice; busy <= 1 if slice != 0.
REQ-016 Zero load: if the slice is 0, busy stays 0 and done pulses in the next cycle.
REQ-017 Each cycle with tick=1 shall decrement every busy channel by 1.
REQ-018 On the tick that takes a channel from 1 to 0: busy clears and done pulses for exactly one cycle.
REQ-019 Latency: a channel loaded with N>0 expires on the N-th tick strictly after the load edge.
REQ-020 cancel on a busy channel shall clear busy and count at the next edge with no done pulse; cancel beats a simultaneous expiry; cancel on an idle channel has no effect and does not block its grant.
REQ-021 Channels are independent: simultaneous expiries on several channels pulse their done bits in the same cycle.
REQ-022 The countdown value never wraps below 0: decrement applies only while busy=1.

Reset
REQ-023 While rst=0: gnt=0, busy=0, done=0, tick=0, prescaler=0, ptr=0, all counts=0.
REQ-024 Reset asserted mid-countdown shall abort all channels with no done pulse; after release the prescaler restarts from 0.

Configuration
REQ-025 Macro TICK_TIMER_SCHED_RELOAD_EN defined: extra input port reload, 4 bits, is present; a channel expiring with reload=1 pulses done, reloads its last granted value and keeps busy=1. A reloaded value of 0 is impossible, because zero loads never set busy.
REQ-026 Macro undefined: port reload is absent and every channel is strictly one-shot per REQ-018.

Verification (DIV=4, CNT_W=8)
REQ-027 Reset release, idle inputs -> tick pulses every 4th cycle, starting 4 cycles after release; gnt, busy and done stay 0.
REQ-028 req=0001 with load 3 -> gnt=0001 for 1 cycle, busy[0]=1, done[0] pulses 1 cycle after the 3rd subsequent tick, then busy[0]=0.
REQ-029 req=1111 held, all loads 2 -> grants issue in order 0,1,2,3 on consecutive cycles; each channel is granted once only while busy.
REQ-030 Channel 2 loaded with 5, cancel[2] asserted in the same cycle as its expiring tick -> busy[2] clears and done[2] never pulses.
REQ-031 Load 0 on channel 1 -> busy[1] stays 0 and done[1] pulses the next cycle; rst=0 during a 10-tick countdown -> all outputs go 0 at once with no done pulse.
REQ-032 With TICK_TIMER_SCHED_RELOAD_EN, reload[3]=1 and load 2 -> done[3] pulses every 2 ticks with busy[3] held 1; clearing reload[3] -> the next expiry is final.

Source files
------------

// File: rtl/tick_timer_sched.sv
// tick_timer_sched
// Four-channel countdown timer driven by one shared timebase tick.
// Channels are started through a round-robin arbiter, one grant per cycle.
// A granted channel loads its start value and counts down once per tick.
// When it reaches zero it raises a one-cycle done pulse.
//
// Optional feature: define TICK_TIMER_SCHED_RELOAD_EN to add the 'reload'
// input. A channel that expires with its reload bit set pulses done, restores
// its last granted value and stays busy. Without the macro every channel is
// strictly one-shot.
//
// Handshake: a requester holds req[i] high until it sees gnt[i]. gnt is
// combinational. The load happens at the clock edge that ends the grant
// cycle. A channel is eligible only while req[i]=1 and busy[i]=0.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   rst       asynchronous active-low reset
//   req       per-channel start request
//   load_val  per-channel start value, channel i at [i*CNT_W +: CNT_W]
//   cancel    per-channel abort of a running countdown
//   reload    (TICK_TIMER_SCHED_RELOAD_EN only) per-channel auto-restart
//   gnt       one-hot grant (combinational)
//   busy      channel is counting (registered)
//   done      one-cycle expiry pulse (registered)
//   tick      one-cycle timebase pulse (registered)
module tick_timer_sched #(
    parameter int DIV   = 5000000,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*CNT_W-1:0] load_val,
    input  logic [3:0]         cancel,
`ifdef TICK_TIMER_SCHED_RELOAD_EN
    input  logic [3:0]         reload,
`endif
    output logic [3:0]         gnt,
    output logic [3:0]         busy,
    output logic [3:0]         done,
    output logic               tick
);

    localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0]    pre;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt [4];
`ifdef TICK_TIMER_SCHED_RELOAD_EN
    logic [CNT_W-1:0] last [4];
`endif

    logic [3:0] elig;
    logic       gnt_any;
    logic [1:0] gnt_idx;
    logic [1:0] idx;

    // Prescaler: counts 0..DIV-1. tick is high in the cycle after the wrap.
    // With DIV=1, PRE_MAX is 0, so the counter wraps on every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre  <= '0;
            tick <= 1'b0;
        end else if (pre == PRE_MAX) begin
            pre  <= '0;
            tick <= 1'b1;
        end else begin
            pre  <= pre + 1'b1;
            tick <= 1'b0;
        end
    end

    // Round-robin arbiter. The search starts at ptr and wraps modulo 4.
    // Busy channels are masked out, so a request from a busy channel waits.
    // The grant is forced low while reset is held, because req may be high
    // during reset.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        elig    = req & ~busy;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!gnt_any && elig[idx]) begin
                gnt_any      = 1'b1;
                gnt_idx      = idx;
                gnt[idx]     = 1'b1;
            end
        end
        if (!rst) begin
            gnt     = '0;
            gnt_any = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= gnt_idx + 2'd1;
        end
    end

    // Channel countdowns. Per channel, the priority order is:
    // grant, then cancel, then tick decrement.
    // A grant only reaches an idle channel, so it never collides with cancel.
    // The decrement applies only while busy, so the count cannot wrap below 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            done <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i]  <= '0;
`ifdef TICK_TIMER_SCHED_RELOAD_EN
                last[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                done[i] <= 1'b0;
                if (gnt[i]) begin
                    cnt[i]  <= load_val[i*CNT_W +: CNT_W];
                    busy[i] <= (load_val[i*CNT_W +: CNT_W] != '0);
                    // A zero load expires immediately and never goes busy.
                    done[i] <= (load_val[i*CNT_W +: CNT_W] == '0);
`ifdef TICK_TIMER_SCHED_RELOAD_EN
                    last[i] <= load_val[i*CNT_W +: CNT_W];
`endif
                end else if (busy[i] && cancel[i]) begin
                    // Cancel wins over a simultaneous expiry and gives no done.
                    busy[i] <= 1'b0;
                    cnt[i]  <= '0;
                end else if (busy[i] && tick) begin
                    if (cnt[i] == CNT_W'(1)) begin
                        done[i] <= 1'b1;
`ifdef TICK_TIMER_SCHED_RELOAD_EN
                        if (reload[i]) begin
                            cnt[i] <= last[i];
                        end else begin
                            cnt[i]  <= '0;
                            busy[i] <= 1'b0;
                        end
`else
                        cnt[i]  <= '0;
                        busy[i] <= 1'b0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_timer_sched.sv
// tb_tick_timer_sched
// Bench for tick_timer_sched with DIV=4 and CNT_W=8.
// cyc counts the clock edges since reset release.
// When a load is granted, the bench computes the cycle in which done must be
// high from the tick schedule and queues it in exp_q as {cycle, channel},
// kept sorted. A monitor on the falling edge checks done against the queue
// head and checks tick against the known schedule.
module tb_tick_timer_sched;

    localparam int DIV   = 4;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [3:0]         req = '0;
    logic [4*CNT_W-1:0] load_val = '0;
    logic [3:0]         cancel = '0;
`ifdef TICK_TIMER_SCHED_RELOAD_EN
    logic [3:0]         reload = '0;
`endif
    logic [3:0]         gnt;
    logic [3:0]         busy;
    logic [3:0]         done;
    logic               tick;

    tick_timer_sched #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .load_val (load_val),
        .cancel   (cancel),
`ifdef TICK_TIMER_SCHED_RELOAD_EN
        .reload   (reload),
`endif
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .tick     (tick)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Cycle in which done is high for a load of n taken at edge e.
    // Tick is high in cycles that are multiples of DIV (from DIV on).
    // The n-th such cycle at or after e decrements at the next edge.
    function automatic int exp_done_cycle(input int e, input int n);
        int t;
        if (n == 0) return e;
        t = ((e + DIV - 1) / DIV) * DIV + DIV * (n - 1);
        return t + 1;
    endfunction

    task automatic push_exp(input int c, input int ch);
        logic [31:0] v;
        int i;
        v = {c[29:0], ch[1:0]};
        i = 0;
        while (i < exp_q.size() && exp_q[i] < v) i++;
        exp_q.insert(i, v);
    endtask

    logic [31:0] key;
    logic        e_bit;
    always @(negedge clk) begin
        if (rst) begin
            chk("tick", {31'd0, tick}, {31'd0, (cyc >= DIV) && (cyc % DIV == 0)});
            while (exp_q.size() > 0 && exp_q[0][31:2] < cyc[29:0]) begin
                chk("done_missed", cyc, {2'b00, exp_q[0][31:2]});
                void'(exp_q.pop_front());
            end
            for (int ch = 0; ch < 4; ch++) begin
                key   = {cyc[29:0], ch[1:0]};
                e_bit = (exp_q.size() > 0) && (exp_q[0] == key);
                chk($sformatf("done%0d", ch), {31'd0, done[ch]}, {31'd0, e_bit});
                if (e_bit) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_load(input int ch, input int v);
        load_val[ch*CNT_W +: CNT_W] = v[CNT_W-1:0];
    endtask

    task automatic wait_until(input int c);
        for (int i = 0; i < 400 && cyc < c; i++) @(negedge clk);
        chk("wait_bound", {31'd0, cyc >= c}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        req    = '0;
        cancel = '0;
        #1;
        chk("rst_gnt", {28'd0, gnt}, 0);
        chk("rst_busy", {28'd0, busy}, 0);
        chk("rst_done", {28'd0, done}, 0);
        chk("rst_tick", {31'd0, tick}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int d, d1, d2, d3;

    initial begin
        // Reset held with every channel requesting: grant must stay low.
        req = 4'hF;
        for (int ch = 0; ch < 4; ch++) set_load(ch, 5);
        repeat (3) @(negedge clk);
        chk("rst0_gnt", {28'd0, gnt}, 0);
        chk("rst0_busy", {28'd0, busy}, 0);
        chk("rst0_done", {28'd0, done}, 0);
        chk("rst0_tick", {31'd0, tick}, 0);
        req = '0;
        rst = 1'b1;

        // Idle after release: the monitor checks tick on cycles 4, 8, 12.
        repeat (12) begin
            @(negedge clk);
            chk("idle_gnt", {28'd0, gnt}, 0);
            chk("idle_busy", {28'd0, busy}, 0);
        end

        // Single load of 3 on channel 0.
        set_load(0, 3);
        req = 4'b0001;
        #1 chk("g028", {28'd0, gnt}, 32'h1);
        d = exp_done_cycle(cyc + 1, 3);
        push_exp(d, 0);
        @(negedge clk);
        req = '0;
        chk("g028_off", {28'd0, gnt}, 0);
        chk("busy028", {28'd0, busy}, 32'h1);
        wait_until(d);
        chk("busy028_end", {28'd0, busy}, 0);
        wait_drain();

        // All four channels request with load 2: grant order is 0,1,2,3.
        do_reset();
        req = 4'hF;
        for (int ch = 0; ch < 4; ch++) set_load(ch, 2);
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("g029_%0d", k), {28'd0, gnt}, 32'd1 << k);
            push_exp(exp_done_cycle(cyc + 1, 2), k);
            @(negedge clk);
        end
        #1 chk("g029_busyblk", {28'd0, gnt}, 0);
        chk("busy029", {28'd0, busy}, 32'hF);
        req = '0;
        wait_drain();

        // Round-robin pointer: ptr is 0 after the grant to channel 3.
        set_load(1, 1);
        set_load(3, 1);
        req = 4'b1010;
        #1 chk("rr_a", {28'd0, gnt}, 32'h2);
        push_exp(exp_done_cycle(cyc + 1, 1), 1);
        @(negedge clk);
        set_load(0, 1);
        req = 4'b1001;
        #1 chk("rr_b", {28'd0, gnt}, 32'h8);
        push_exp(exp_done_cycle(cyc + 1, 1), 3);
        @(negedge clk);
        req = 4'b0001;
        #1 chk("rr_c", {28'd0, gnt}, 32'h1);
        push_exp(exp_done_cycle(cyc + 1, 1), 0);
        @(negedge clk);
        req = '0;
        wait_drain();

        // Cancel in the same cycle as the expiring tick: no done pulse.
        set_load(2, 5);
        req = 4'b0100;
        #1 chk("g030", {28'd0, gnt}, 32'h4);
        d = exp_done_cycle(cyc + 1, 5);
        @(negedge clk);
        req = '0;
        wait_until(d - 1);
        chk("busy030_pre", {31'd0, busy[2]}, 1);
        cancel = 4'b0100;
        @(negedge clk);
        cancel = '0;
        chk("busy030_post", {31'd0, busy[2]}, 0);
        repeat (8) @(negedge clk);
        chk("busy030_idle", {28'd0, busy}, 0);

        // Zero load on channel 1, with a cancel on the idle channel in the
        // same cycle.
        set_load(1, 0);
        req    = 4'b0010;
        cancel = 4'b0010;
        #1 chk("g031z", {28'd0, gnt}, 32'h2);
        push_exp(exp_done_cycle(cyc + 1, 0), 1);
        @(negedge clk);
        req    = '0;
        cancel = '0;
        chk("busy031z", {28'd0, busy}, 0);
        wait_drain();

        // Two channels expiring in the same cycle.
        for (int i = 0; i < 8 && (cyc % DIV) != 1; i++) @(negedge clk);
        set_load(0, 2);
        req = 4'b0001;
        #1 chk("g021_a", {28'd0, gnt}, 32'h1);
        push_exp(exp_done_cycle(cyc + 1, 2), 0);
        @(negedge clk);
        set_load(1, 2);
        req = 4'b0010;
        #1 chk("g021_b", {28'd0, gnt}, 32'h2);
        push_exp(exp_done_cycle(cyc + 1, 2), 1);
        @(negedge clk);
        req = '0;
        wait_drain();

        // Reset in the middle of a 10-tick countdown: no done pulse.
        set_load(3, 10);
        req = 4'b1000;
        #1 chk("g031r", {28'd0, gnt}, 32'h8);
        @(negedge clk);
        req = '0;
        repeat (8) @(negedge clk);
        chk("busy031r_pre", {28'd0, busy}, 32'h8);
        rst = 1'b0;
        #1;
        chk("rstmid_busy", {28'd0, busy}, 0);
        chk("rstmid_done", {28'd0, done}, 0);
        chk("rstmid_tick", {31'd0, tick}, 0);
        chk("rstmid_gnt", {28'd0, gnt}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_busy", {28'd0, busy}, 0);
        end

`ifdef TICK_TIMER_SCHED_RELOAD_EN
        // Auto-reload on channel 3, then a final expiry after reload clears.
        set_load(3, 2);
        reload = 4'b1000;
        req    = 4'b1000;
        #1 chk("g032", {28'd0, gnt}, 32'h8);
        d1 = exp_done_cycle(cyc + 1, 2);
        d2 = exp_done_cycle(d1, 2);
        d3 = exp_done_cycle(d2, 2);
        push_exp(d1, 3);
        push_exp(d2, 3);
        push_exp(d3, 3);
        @(negedge clk);
        req = '0;
        wait_until(d2);
        chk("busy032_held", {28'd0, busy}, 32'h8);
        reload = '0;
        wait_until(d3);
        chk("busy032_final", {28'd0, busy}, 0);
        wait_drain();
`endif

        repeat (4) @(negedge clk);
        chk("q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
